wb_sched: RTL and testbench
===========================

Name: wb_sched

Overview:
- Writeback scheduler for the register-file write port, which is fed through the reg_write_mux datapath.
- Accepts retiring instructions from execute and tracks outstanding loads until memory responds.
- Arbitrates the single write port between the pipeline and a debug write requester.
- Drives the mux data lanes, the 2-bit mux select, and the regfile write enable/address.

Parameters:
MEM_TIMEOUT, 16, cycles to wait for a load response before aborting (>=1)
DBG_MAX_WAIT, 4, consecutive cycles a pending debug request may be blocked by pipeline accepts before it is forced through (>=1)
XLEN, 32, data width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
io_ex_valid  in  1  execute stage presents a retiring instruction
io_ex_ready  out  1  scheduler accepts it this cycle
io_ex_rd  in  5  destination register
io_ex_wb_sel  in  2  0=load data, 1=ALU, 2=PC+4, 3=no writeback
io_ex_alu_out  in  XLEN  ALU result
io_ex_pc_4  in  XLEN  PC+4
io_mem_resp_valid  in  1  load data valid (single-cycle pulse)
io_mem_resp_data  in  XLEN  load data
io_mem_err  out  1  one-cycle pulse on load timeout
io_dbg_req  in  1  debug write request, level, held until ack
io_dbg_rd  in  5  debug destination register
io_dbg_data  in  XLEN  debug write data
io_dbg_ack  out  1  one-cycle pulse in the debug write cycle
io_data_mem  out  XLEN  mux lane 0
io_alu_out  out  XLEN  mux lane 1
io_pc_4  out  XLEN  mux lane 2
io_reg_write_mux_sel  out  2  mux select
io_reg_wen  out  1  regfile write enable
io_reg_waddr  out  5  regfile write address
io_busy  out  1  state != IDLE

Behaviour:
- States: IDLE, WAIT_MEM, WRITE.
- All outputs are registered.
- Reset (asserted low, asynchronous):
  - state=IDLE.
  - Every data lane, sel, waddr and the starvation counter clear to 0.
  - wen, mem_err, dbg_ack and busy are 0.
  - io_ex_ready=1 after reset is released.
  - Reset mid-load abandons the load; a later stray resp_valid is ignored in IDLE.
- io_ex_ready = (state==IDLE) && !dbg_win. Combinational.
- dbg_win = io_dbg_req && (!io_ex_valid || starve==DBG_MAX_WAIT).
- IDLE, dbg_win:
  - Latch io_dbg_rd and io_dbg_data; the data goes onto the io_alu_out lane.
  - Set sel=1 and go to WRITE.
  - The write cycle pulses io_dbg_ack.
- IDLE, ex accepted (valid && ready):
  - wb_sel=1 or 2: latch rd and the corresponding lane, set sel=wb_sel, go to WRITE. wen is asserted exactly 1 cycle after accept.
  - wb_sel=0: latch rd, clear the timer, go to WAIT_MEM.
  - wb_sel=3: consumed, no write, remain IDLE.
- starve counter:
  - Increments, saturating at DBG_MAX_WAIT, on each accept while io_dbg_req=1.
  - Clears on debug grant or when io_dbg_req=0.
- WAIT_MEM, resp_valid:
  - Latch io_mem_resp_data onto lane 0, sel=0, go to WRITE. wen is asserted 1 cycle after resp_valid.
  - resp_valid in the same cycle the timer reaches MEM_TIMEOUT: the response wins and no error is raised.
- WAIT_MEM, timer==MEM_TIMEOUT without response: pulse io_mem_err, return to IDLE, no write.
- WRITE:
  - wen=1 for exactly one cycle with the latched waddr, sel and lanes, then go to IDLE.
  - rd==0 forces wen=0; the cycle, state flow and dbg_ack are otherwise unchanged.
- Outside WRITE: wen=0. Lanes, sel and waddr hold their last values.
- Throughput: at most one write every 2 cycles; io_ex_ready=0 in WAIT_MEM and WRITE.
- resp_valid outside WAIT_MEM is ignored.

Decomposition:
- Shared package holds:
  - WB_SEL_MEM=0, WB_SEL_ALU=1, WB_SEL_PC4=2, WB_SEL_NONE=3 (also used by reg_write_mux users).
  - The state enum {IDLE, WAIT_MEM, WRITE}.
  - REG_ADDR_W=5.
- One natural sub-module: wb_port_arbiter, holding the dbg_win logic and the starve counter.
- The FSM, timer and lane registers stay in wb_sched.

Test Plan:
- Basic writes: ALU op rd=5, alu_out=0x1234_5678, accepted cycle N -> cycle N+1: wen=1, waddr=5, sel=1, io_alu_out=0x12345678; cycle N+2: wen=0, ready=1.
- Load: wb_sel=0 rd=7, then resp_valid after 3 cycles with 0xDEAD_BEEF -> wen=1 the next cycle, sel=0, io_data_mem=0xDEADBEEF; busy=1 throughout; ex_ready=0 until return to IDLE.
- Load timeout: wb_sel=0 with no response for MEM_TIMEOUT=16 cycles -> io_mem_err pulses for 1 cycle, wen stays 0, IDLE on the next cycle; a late resp_valid is ignored.
- rd=0: PC+4 op rd=0 and pc_4=0x100 -> sel=2, lane=0x100, wen=0.
  - Debug write to rd=0 -> dbg_ack=1, wen=0.
- Starvation: io_dbg_req (rd=3, data=0xA5A5_A5A5) held while ex_valid stays 1 with back-to-back ALU ops -> after 4 pipeline accepts, debug is granted, ex_ready=0, then wen=1, waddr=3, sel=1, lane=0xA5A5A5A5, dbg_ack=1.
- Reset mid-operation: reset asserted low while in WAIT_MEM -> all outputs clear immediately, without waiting for a clock edge; after release, ready=1 and a resp_valid causes no write.

Source files
------------

// File: rtl/wb_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_sched_pkg
// Description : Shared definitions for the writeback scheduler. Holds the
//               write-port mux lane encodings, the register address width
//               and the scheduler state type.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_sched_pkg;

  localparam int REG_ADDR_W = 5;

  // Writeback source / reg_write_mux select encodings
  localparam logic [1:0] WB_SEL_MEM  = 2'd0;
  localparam logic [1:0] WB_SEL_ALU  = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } state_t;

endpackage : wb_sched_pkg
`default_nettype wire

// File: rtl/wb_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_sched_if
// Description : Bundle of execute, memory-response, debug and write-port
//               signals around the writeback scheduler.
//               slave  : scheduler side
//               master : environment side (execute, memory, debug, regfile)
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_sched_if #(
  parameter int XLEN = 32
);
  import wb_sched_pkg::*;

  // execute handshake
  logic                  io_ex_valid;
  logic                  io_ex_ready;
  logic [REG_ADDR_W-1:0] io_ex_rd;
  logic [1:0]            io_ex_wb_sel;
  logic [XLEN-1:0]       io_ex_alu_out;
  logic [XLEN-1:0]       io_ex_pc_4;
  // memory response
  logic                  io_mem_resp_valid;
  logic [XLEN-1:0]       io_mem_resp_data;
  logic                  io_mem_err;
  // debug write requester
  logic                  io_dbg_req;
  logic [REG_ADDR_W-1:0] io_dbg_rd;
  logic [XLEN-1:0]       io_dbg_data;
  logic                  io_dbg_ack;
  // reg_write_mux lanes and regfile write port
  logic [XLEN-1:0]       io_data_mem;
  logic [XLEN-1:0]       io_alu_out;
  logic [XLEN-1:0]       io_pc_4;
  logic [1:0]            io_reg_write_mux_sel;
  logic                  io_reg_wen;
  logic [REG_ADDR_W-1:0] io_reg_waddr;
  logic                  io_busy;

  modport slave (
    input  io_ex_valid, io_ex_rd, io_ex_wb_sel, io_ex_alu_out, io_ex_pc_4,
    input  io_mem_resp_valid, io_mem_resp_data,
    input  io_dbg_req, io_dbg_rd, io_dbg_data,
    output io_ex_ready, io_mem_err, io_dbg_ack,
    output io_data_mem, io_alu_out, io_pc_4, io_reg_write_mux_sel,
    output io_reg_wen, io_reg_waddr, io_busy
  );

  modport master (
    output io_ex_valid, io_ex_rd, io_ex_wb_sel, io_ex_alu_out, io_ex_pc_4,
    output io_mem_resp_valid, io_mem_resp_data,
    output io_dbg_req, io_dbg_rd, io_dbg_data,
    input  io_ex_ready, io_mem_err, io_dbg_ack,
    input  io_data_mem, io_alu_out, io_pc_4, io_reg_write_mux_sel,
    input  io_reg_wen, io_reg_waddr, io_busy
  );

endinterface : wb_sched_if
`default_nettype wire

// File: rtl/wb_sched_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Decides whether a pending debug write wins the register-file
//               write port over the pipeline, with a starvation counter that
//               forces debug through after DBG_MAX_WAIT pipeline accepts.
// Ports       : clock, reset (async, active-low)
//               i_dbg_req  - debug request level
//               i_ex_valid - execute presents an instruction
//               i_accept   - pipeline instruction accepted this cycle
//               i_grant    - debug write granted this cycle
//               o_dbg_win  - debug would win the port this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int DBG_MAX_WAIT = 4
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic i_dbg_req,
  input  wire logic i_ex_valid,
  input  wire logic i_accept,
  input  wire logic i_grant,
  output logic      o_dbg_win
);

  localparam int             CNT_W = $clog2(DBG_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(DBG_MAX_WAIT);

  logic [CNT_W-1:0] r_starve;

  // Counts pipeline accepts that overtook a waiting debug request; saturates
  // so the forced grant stays asserted until it is actually taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_starve <= '0;
    end else if (!i_dbg_req || i_grant) begin
      r_starve <= '0;
    end else if (i_accept && (r_starve != C_MAX)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  assign o_dbg_win = i_dbg_req && (!i_ex_valid || (r_starve == C_MAX));

endmodule : wb_port_arbiter
`default_nettype wire

// File: rtl/wb_sched.sv
`default_nettype none
// ============================================================================
// Module      : wb_sched
// Description : Writeback scheduler for the register-file write port. Accepts
//               retiring instructions, waits for load data with a timeout,
//               arbitrates against debug writes and drives the reg_write_mux
//               lanes, select and regfile write enable/address.
// Ports       : clock - rising-edge clock
//               reset - asynchronous active-low reset
//               bus   - wb_sched_if.slave (execute, memory, debug, write port)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_sched
  import wb_sched_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 16,
  parameter int DBG_MAX_WAIT = 4,
  parameter int XLEN         = 32
) (
  input  wire logic clock,
  input  wire logic reset,
  wb_sched_if.slave bus
);

  localparam int               TMR_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] C_TIMEOUT = TMR_W'(MEM_TIMEOUT);

  state_t                r_state, w_state_nxt;
  logic [TMR_W-1:0]      r_timer, w_timer_nxt;
  logic [REG_ADDR_W-1:0] r_load_rd, w_load_rd_nxt;
  logic [XLEN-1:0]       r_data_mem, w_data_mem_nxt;
  logic [XLEN-1:0]       r_alu, w_alu_nxt;
  logic [XLEN-1:0]       r_pc4, w_pc4_nxt;
  logic [1:0]            r_sel, w_sel_nxt;
  logic [REG_ADDR_W-1:0] r_waddr, w_waddr_nxt;
  logic                  r_wen, w_wen_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_ack, w_ack_nxt;
  logic                  r_busy;

  logic w_dbg_win;
  logic w_idle;
  logic w_ready;
  logic w_accept;
  logic w_grant;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_ready  = w_idle && !w_dbg_win;
  assign w_accept = bus.io_ex_valid && w_ready;
  assign w_grant  = w_idle && w_dbg_win;

  wb_port_arbiter #(
    .DBG_MAX_WAIT (DBG_MAX_WAIT)
  ) u_arb (
    .clock      (clock),
    .reset      (reset),
    .i_dbg_req  (bus.io_dbg_req),
    .i_ex_valid (bus.io_ex_valid),
    .i_accept   (w_accept),
    .i_grant    (w_grant),
    .o_dbg_win  (w_dbg_win)
  );

  // Next-state and next-output logic. Every output is produced one cycle
  // ahead here so the registered copies line up with the state they belong to.
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_load_rd_nxt  = r_load_rd;
    w_data_mem_nxt = r_data_mem;
    w_alu_nxt      = r_alu;
    w_pc4_nxt      = r_pc4;
    w_sel_nxt      = r_sel;
    w_waddr_nxt    = r_waddr;
    w_wen_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    w_ack_nxt      = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          // debug data travels on the ALU lane
          w_alu_nxt   = bus.io_dbg_data;
          w_sel_nxt   = WB_SEL_ALU;
          w_waddr_nxt = bus.io_dbg_rd;
          w_wen_nxt   = (bus.io_dbg_rd != '0);
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_WRITE;
        end else if (w_accept) begin
          unique case (bus.io_ex_wb_sel)
            WB_SEL_MEM: begin
              w_load_rd_nxt = bus.io_ex_rd;
              w_timer_nxt   = '0;
              w_state_nxt   = ST_WAIT_MEM;
            end
            WB_SEL_ALU: begin
              w_alu_nxt   = bus.io_ex_alu_out;
              w_sel_nxt   = WB_SEL_ALU;
              w_waddr_nxt = bus.io_ex_rd;
              w_wen_nxt   = (bus.io_ex_rd != '0);
              w_state_nxt = ST_WRITE;
            end
            WB_SEL_PC4: begin
              w_pc4_nxt   = bus.io_ex_pc_4;
              w_sel_nxt   = WB_SEL_PC4;
              w_waddr_nxt = bus.io_ex_rd;
              w_wen_nxt   = (bus.io_ex_rd != '0);
              w_state_nxt = ST_WRITE;
            end
            default: ; // no writeback: instruction retires in place
          endcase
        end
      end
      ST_WAIT_MEM: begin
        // A response arriving on the timeout cycle still wins.
        if (bus.io_mem_resp_valid) begin
          w_data_mem_nxt = bus.io_mem_resp_data;
          w_sel_nxt      = WB_SEL_MEM;
          w_waddr_nxt    = r_load_rd;
          w_wen_nxt      = (r_load_rd != '0);
          w_state_nxt    = ST_WRITE;
        end else if (r_timer == C_TIMEOUT) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      ST_WRITE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_load_rd  <= '0;
      r_data_mem <= '0;
      r_alu      <= '0;
      r_pc4      <= '0;
      r_sel      <= '0;
      r_waddr    <= '0;
      r_wen      <= 1'b0;
      r_err      <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_load_rd  <= w_load_rd_nxt;
      r_data_mem <= w_data_mem_nxt;
      r_alu      <= w_alu_nxt;
      r_pc4      <= w_pc4_nxt;
      r_sel      <= w_sel_nxt;
      r_waddr    <= w_waddr_nxt;
      r_wen      <= w_wen_nxt;
      r_err      <= w_err_nxt;
      r_ack      <= w_ack_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.io_ex_ready          = w_ready;
  assign bus.io_mem_err           = r_err;
  assign bus.io_dbg_ack           = r_ack;
  assign bus.io_data_mem          = r_data_mem;
  assign bus.io_alu_out           = r_alu;
  assign bus.io_pc_4              = r_pc4;
  assign bus.io_reg_write_mux_sel = r_sel;
  assign bus.io_reg_wen           = r_wen;
  assign bus.io_reg_waddr         = r_waddr;
  assign bus.io_busy              = r_busy;

endmodule : wb_sched
`default_nettype wire

// File: tb/tb_wb_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_sched
// Description : Self-checking bench for wb_sched. Directed scenarios followed
//               by a randomized mix of operations; expected lane/select/
//               address values and a register-file image are kept by the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_sched;

  localparam int MEM_TIMEOUT  = 16;
  localparam int DBG_MAX_WAIT = 4;
  localparam int XLEN         = 32;

  logic clock;
  logic reset;

  int checks   = 0;
  int failures = 0;

  // expected view of the write port as the bench understands it
  logic [31:0] m_mem, m_alu, m_pc4;
  logic [1:0]  m_sel;
  logic [4:0]  m_waddr;
  logic [31:0] rf_exp [32];
  logic [31:0] rf_obs [32];

  wb_sched_if #(.XLEN(XLEN)) bus ();

  wb_sched #(
    .MEM_TIMEOUT  (MEM_TIMEOUT),
    .DBG_MAX_WAIT (DBG_MAX_WAIT),
    .XLEN         (XLEN)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Register file as seen through the mux, captured mid-cycle.
  always @(negedge clock) begin
    if (reset && bus.io_reg_wen) begin
      case (bus.io_reg_write_mux_sel)
        2'd0:    rf_obs[bus.io_reg_waddr] = bus.io_data_mem;
        2'd1:    rf_obs[bus.io_reg_waddr] = bus.io_alu_out;
        2'd2:    rf_obs[bus.io_reg_waddr] = bus.io_pc_4;
        default: rf_obs[bus.io_reg_waddr] = 32'hBAD0_BAD0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_port(input string tag);
    check({tag, "_sel"},   32'(bus.io_reg_write_mux_sel), 32'(m_sel));
    check({tag, "_waddr"}, 32'(bus.io_reg_waddr), 32'(m_waddr));
    check({tag, "_lane0"}, bus.io_data_mem, m_mem);
    check({tag, "_lane1"}, bus.io_alu_out, m_alu);
    check({tag, "_lane2"}, bus.io_pc_4, m_pc4);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_wen"},   32'(bus.io_reg_wen), 0);
    check({tag, "_ready"}, 32'(bus.io_ex_ready), 1);
    check({tag, "_busy"},  32'(bus.io_busy), 0);
    check_port(tag);
  endtask

  // ALU / PC+4 / no-writeback instruction
  task automatic do_exec(input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc4);
    check("exec_ready_before", 32'(bus.io_ex_ready), 1);
    bus.io_ex_valid = 1'b1; bus.io_ex_rd = rd; bus.io_ex_wb_sel = sel;
    bus.io_ex_alu_out = alu; bus.io_ex_pc_4 = pc4;
    tick();
    bus.io_ex_valid = 1'b0;
    if (sel == 2'd1 || sel == 2'd2) begin
      m_sel = sel; m_waddr = rd;
      if (sel == 2'd1) m_alu = alu; else m_pc4 = pc4;
      if (rd != 0) rf_exp[rd] = (sel == 2'd1) ? alu : pc4;
      check("exec_wen",   32'(bus.io_reg_wen), 32'(rd != 0));
      check("exec_ready", 32'(bus.io_ex_ready), 0);
      check("exec_busy",  32'(bus.io_busy), 1);
      check_port("exec_write");
      tick();
    end
    check_idle("exec_after");
  endtask

  // Load answered after 'delay' cycles in the wait state (0..MEM_TIMEOUT)
  task automatic do_load(input logic [4:0] rd, input logic [31:0] data, input int delay);
    bus.io_ex_valid = 1'b1; bus.io_ex_rd = rd; bus.io_ex_wb_sel = 2'd0;
    tick();
    bus.io_ex_valid = 1'b0;
    for (int k = 0; k < delay; k++) begin
      check("load_wait_busy",  32'(bus.io_busy), 1);
      check("load_wait_ready", 32'(bus.io_ex_ready), 0);
      check("load_wait_wen",   32'(bus.io_reg_wen), 0);
      tick();
    end
    check("load_busy_at_resp", 32'(bus.io_busy), 1);
    bus.io_mem_resp_valid = 1'b1; bus.io_mem_resp_data = data;
    tick();
    bus.io_mem_resp_valid = 1'b0;
    m_sel = 2'd0; m_waddr = rd; m_mem = data;
    if (rd != 0) rf_exp[rd] = data;
    check("load_wen",   32'(bus.io_reg_wen), 32'(rd != 0));
    check("load_err",   32'(bus.io_mem_err), 0);
    check("load_ready", 32'(bus.io_ex_ready), 0);
    check_port("load_write");
    tick();
    check_idle("load_after");
  endtask

  // Load that never gets an answer; a stray response follows the abort
  task automatic do_timeout(input logic [4:0] rd);
    bus.io_ex_valid = 1'b1; bus.io_ex_rd = rd; bus.io_ex_wb_sel = 2'd0;
    tick();
    bus.io_ex_valid = 1'b0;
    for (int k = 0; k < MEM_TIMEOUT; k++) begin
      check("tmo_err_early", 32'(bus.io_mem_err), 0);
      tick();
    end
    check("tmo_busy_last", 32'(bus.io_busy), 1);
    tick();
    check("tmo_err_pulse", 32'(bus.io_mem_err), 1);
    check_idle("tmo_abort");
    bus.io_mem_resp_valid = 1'b1; bus.io_mem_resp_data = 32'hFFFF_0000;
    tick();
    bus.io_mem_resp_valid = 1'b0;
    check("tmo_err_single", 32'(bus.io_mem_err), 0);
    check_idle("tmo_stray_resp");
  endtask

  task automatic do_debug(input logic [4:0] rd, input logic [31:0] data);
    bus.io_dbg_req = 1'b1; bus.io_dbg_rd = rd; bus.io_dbg_data = data;
    #1;
    check("dbg_ready_blocked", 32'(bus.io_ex_ready), 0);
    tick();
    bus.io_dbg_req = 1'b0;
    m_sel = 2'd1; m_waddr = rd; m_alu = data;
    if (rd != 0) rf_exp[rd] = data;
    check("dbg_ack", 32'(bus.io_dbg_ack), 1);
    check("dbg_wen", 32'(bus.io_reg_wen), 32'(rd != 0));
    check_port("dbg_write");
    tick();
    check("dbg_ack_single", 32'(bus.io_dbg_ack), 0);
    check_idle("dbg_after");
  endtask

  initial begin
    logic [31:0] d;
    logic [4:0]  r;
    int          accepts;

    for (int i = 0; i < 32; i++) begin rf_exp[i] = '0; rf_obs[i] = '0; end
    m_mem = '0; m_alu = '0; m_pc4 = '0; m_sel = '0; m_waddr = '0;
    bus.io_ex_valid = 1'b0; bus.io_ex_rd = '0; bus.io_ex_wb_sel = 2'd3;
    bus.io_ex_alu_out = '0; bus.io_ex_pc_4 = '0;
    bus.io_mem_resp_valid = 1'b0; bus.io_mem_resp_data = '0;
    bus.io_dbg_req = 1'b0; bus.io_dbg_rd = '0; bus.io_dbg_data = '0;

    // reset values
    reset = 1'b0;
    #12;
    check("rst_err", 32'(bus.io_mem_err), 0);
    check("rst_ack", 32'(bus.io_dbg_ack), 0);
    check_idle("rst");
    tick();
    reset = 1'b1;
    tick();
    check_idle("rst_release");

    // directed scenarios
    do_exec(5'd5, 2'd1, 32'h1234_5678, 32'h0);
    do_load(5'd7, 32'hDEAD_BEEF, 3);
    do_load(5'd9, 32'h0BAD_F00D, MEM_TIMEOUT);   // response on the timeout cycle
    do_load(5'd10, 32'h1111_2222, 0);
    do_timeout(5'd8);
    do_exec(5'd0, 2'd2, 32'h0, 32'h0000_0100);
    do_exec(5'd12, 2'd3, 32'h5555_5555, 32'h6666_6666);
    do_debug(5'd0, 32'h7777_7777);
    do_debug(5'd4, 32'hCAFE_0004);

    // starvation: debug waits behind DBG_MAX_WAIT back-to-back accepts
    accepts = 0;
    bus.io_dbg_req = 1'b1; bus.io_dbg_rd = 5'd3; bus.io_dbg_data = 32'hA5A5_A5A5;
    bus.io_ex_valid = 1'b1; bus.io_ex_wb_sel = 2'd1;
    for (int n = 0; n < DBG_MAX_WAIT; n++) begin
      r = 5'(n + 20); d = 32'h5000_0000 + 32'(n);
      bus.io_ex_rd = r; bus.io_ex_alu_out = d;
      #1;
      check("starve_ready", 32'(bus.io_ex_ready), 1);
      tick();
      accepts++;
      m_sel = 2'd1; m_waddr = r; m_alu = d; rf_exp[r] = d;
      check("starve_pipe_wen", 32'(bus.io_reg_wen), 1);
      check("starve_pipe_ack", 32'(bus.io_dbg_ack), 0);
      check_port("starve_pipe");
      tick();
    end
    check("starve_accepts", 32'(accepts), 32'(DBG_MAX_WAIT));
    check("starve_ready_forced", 32'(bus.io_ex_ready), 0);
    tick();
    bus.io_dbg_req = 1'b0; bus.io_ex_valid = 1'b0;
    m_sel = 2'd1; m_waddr = 5'd3; m_alu = 32'hA5A5_A5A5; rf_exp[3] = 32'hA5A5_A5A5;
    check("starve_dbg_ack", 32'(bus.io_dbg_ack), 1);
    check("starve_dbg_wen", 32'(bus.io_reg_wen), 1);
    check_port("starve_dbg");
    tick();
    check_idle("starve_after");

    // randomized mix
    for (int it = 0; it < 40; it++) begin
      r = 5'($urandom_range(0, 31));
      d = $urandom;
      case ($urandom_range(0, 5))
        0: do_exec(r, 2'd1, d, $urandom);
        1: do_exec(r, 2'd2, $urandom, d);
        2: do_exec(r, 2'd3, d, $urandom);
        3: do_load(r, d, int'($urandom_range(0, MEM_TIMEOUT)));
        4: do_debug(r, d);
        default: begin
          if ($urandom_range(0, 3) == 0) do_timeout(r);
          else do_load(r, d, int'($urandom_range(0, 4)));
        end
      endcase
    end

    // reset in the middle of a load
    bus.io_ex_valid = 1'b1; bus.io_ex_rd = 5'd15; bus.io_ex_wb_sel = 2'd0;
    tick();
    bus.io_ex_valid = 1'b0;
    tick();
    check("midrst_busy_before", 32'(bus.io_busy), 1);
    #2;
    reset = 1'b0;
    #1;
    m_mem = '0; m_alu = '0; m_pc4 = '0; m_sel = '0; m_waddr = '0;
    check("midrst_err", 32'(bus.io_mem_err), 0);
    check_idle("midrst_async");
    tick();
    reset = 1'b1;
    tick();
    check_idle("midrst_release");
    bus.io_mem_resp_valid = 1'b1; bus.io_mem_resp_data = 32'h1357_9BDF;
    tick();
    bus.io_mem_resp_valid = 1'b0;
    check_idle("midrst_stray_resp");
    tick();

    // register file image built through the write port
    for (int i = 0; i < 32; i++) begin
      check($sformatf("rf_x%0d", i), rf_obs[i], rf_exp[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wb_sched
`default_nettype wire
